// File: rtl/decoder_pkg.sv
// Shared types and constants for the time-multiplexed decoder layer.
// Saturation limits are returned sign-extended to 64 bits; callers narrow them.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BIAS,
        MAC,
        DONE
    } state_t;

    localparam int FRAC_BITS_DEF = 16;

    function automatic logic [63:0] sat_lim(input int bits, input logic neg);
        logic [63:0] max_v;
        max_v = (64'd1 << (bits - 1)) - 64'd1;
        return neg ? ~max_v : max_v;
    endfunction

endpackage

// File: rtl/fixed_point_mac.sv
// One fixed-point multiply-accumulate step: sum = acc + narrow(a*b >>> FRAC_BITS).
// DECODER_MAC_SAT_EN selects saturating narrowing and addition instead of wrap.
module fixed_point_mac
    import decoder_pkg::*;
#(
    parameter int BITSIZE   = 32,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic [BITSIZE-1:0] acc,
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic [BITSIZE-1:0] sum
);

    logic signed [2*BITSIZE-1:0] a_ext;
    logic signed [2*BITSIZE-1:0] b_ext;
    logic signed [2*BITSIZE-1:0] prod;
    logic signed [2*BITSIZE-1:0] prod_sh;
    logic        [BITSIZE-1:0]   narrow;
    logic        [BITSIZE-1:0]   raw_sum;

    assign a_ext   = {{BITSIZE{a[BITSIZE-1]}}, a};
    assign b_ext   = {{BITSIZE{b[BITSIZE-1]}}, b};
    assign prod    = a_ext * b_ext;
    assign prod_sh = prod >>> FRAC_BITS;
    assign raw_sum = acc + narrow;

`ifdef DECODER_MAC_SAT_EN
    localparam logic [BITSIZE-1:0] SMAX = BITSIZE'(sat_lim(BITSIZE, 1'b0));
    localparam logic [BITSIZE-1:0] SMIN = BITSIZE'(sat_lim(BITSIZE, 1'b1));

    logic fits;
    logic ovf;

    // Fits when every bit from BITSIZE-1 upward is a copy of the sign.
    assign fits = (&prod_sh[2*BITSIZE-1:BITSIZE-1])
                | ~(|prod_sh[2*BITSIZE-1:BITSIZE-1]);

    always_comb begin
        narrow = prod_sh[BITSIZE-1:0];
        if (!fits) narrow = prod_sh[2*BITSIZE-1] ? SMIN : SMAX;
    end

    assign ovf = (acc[BITSIZE-1] == narrow[BITSIZE-1])
              && (raw_sum[BITSIZE-1] != acc[BITSIZE-1]);

    always_comb begin
        sum = raw_sum;
        if (ovf) sum = acc[BITSIZE-1] ? SMIN : SMAX;
    end
`else
    logic unused_hi;

    assign unused_hi = ^prod_sh[2*BITSIZE-1:BITSIZE];
    assign narrow    = prod_sh[BITSIZE-1:0];
    assign sum       = raw_sum;
`endif

endmodule

// File: rtl/decoder_mac_scheduler.sv
// Sequences out[j] = b[j] + sum_i z[i]*w[j*N+i] through one shared MAC.
// Build with DECODER_MAC_SAT_EN for saturating arithmetic.
module decoder_mac_scheduler
    import decoder_pkg::*;
#(
    parameter int N_input   = 2,
    parameter int M_output  = 9,
    parameter int BITSIZE   = 32,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_input*BITSIZE-1:0]      z,
    input  logic [N_input*M_output*BITSIZE-1:0] w,
    input  logic [M_output*BITSIZE-1:0]     b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [M_output*BITSIZE-1:0]     out,
    output logic                            busy
);

    localparam int IW = (N_input  > 1) ? $clog2(N_input)  : 1;
    localparam int JW = (M_output > 1) ? $clog2(M_output) : 1;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]               i_q;
    logic [JW-1:0]               j_q;
    logic [BITSIZE-1:0]          acc_q;
    logic [N_input*BITSIZE-1:0]  z_q;
    logic [M_output*BITSIZE-1:0] out_q;
    logic                        out_valid_q;
    logic                        busy_q;

    logic               last_i;
    logic               last_j;
    logic [BITSIZE-1:0] z_sel;
    logic [BITSIZE-1:0] w_sel;
    logic [BITSIZE-1:0] b_sel;
    logic [BITSIZE-1:0] mac_sum;
    int                 w_idx;

    assign last_i = (i_q == IW'(N_input - 1));
    assign last_j = (j_q == JW'(M_output - 1));
    assign w_idx  = int'(j_q) * N_input + int'(i_q);
    assign z_sel  = z_q[int'(i_q)*BITSIZE +: BITSIZE];
    assign w_sel  = w[w_idx*BITSIZE +: BITSIZE];
    assign b_sel  = b[int'(j_q)*BITSIZE +: BITSIZE];

    fixed_point_mac #(
        .BITSIZE   (BITSIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .acc (acc_q),
        .a   (z_sel),
        .b   (w_sel),
        .sum (mac_sum)
    );

    // Flags are decoded from the next state so they toggle with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = BIAS;
            BIAS: state_nxt = MAC;
            MAC:  if (last_i) state_nxt = last_j ? DONE : BIAS;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = out_valid_q;
        busy      = busy_q;
        out       = out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
            z_q   <= '0;
            out_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_q <= z;
                        j_q <= '0;
                    end
                end
                BIAS: begin
                    acc_q <= b_sel;
                    i_q   <= '0;
                end
                MAC: begin
                    i_q <= i_q + 1'b1;
                    if (last_i) begin
                        out_q[int'(j_q)*BITSIZE +: BITSIZE] <= mac_sum;
                        if (!last_j) j_q <= j_q + 1'b1;
                    end else begin
                        acc_q <= mac_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_mac_scheduler.sv
// Scoreboard bench for decoder_mac_scheduler with directed vectors.
// Expected vectors are hand-computed and queued at each accepted input.
module tb_decoder_mac_scheduler;

    localparam int N = 2;
    localparam int M = 9;
    localparam int B = 32;

    typedef logic [M*B-1:0] vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*B-1:0] z = '0;
    logic [N*M*B-1:0] w = '0;
    logic [M*B-1:0] b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [M*B-1:0] out;
    logic           busy;

    decoder_mac_scheduler #(
        .N_input  (N),
        .M_output (M),
        .BITSIZE  (B),
        .FRAC_BITS(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    logic prev_ov = 1'b0;
    vec_t exp_cur = '0;
    vec_t exp_q[$];
    int   lat_q[$];
    int   acc_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Record every accept: expected vector, accept cycle.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(exp_cur);
            lat_q.push_back(cyc + 1);
            acc_log.push_back(cyc + 1);
        end
    end

    always @(negedge clk) begin
        vec_t e;
        int   a;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) begin
                    check("latency_unexpected", vec_t'(1), vec_t'(0));
                end else begin
                    a = lat_q.pop_front();
                    check("latency", vec_t'(cyc - a), vec_t'(27));
                end
            end
            if (out_valid && out_ready) begin
                hs_cyc = cyc + 1;
                if (exp_q.size() == 0) begin
                    check("output_unexpected", vec_t'(1), vec_t'(0));
                end else begin
                    e = exp_q.pop_front();
                    for (int j = 0; j < M; j++)
                        check($sformatf("out_word%0d", j),
                              vec_t'(out[j*B +: B]), vec_t'(e[j*B +: B]));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uniform(input logic [B-1:0] z0, input logic [B-1:0] z1,
                               input logic [B-1:0] wv, input logic [B-1:0] bv,
                               input logic [B-1:0] ev);
        z = {z1, z0};
        for (int k = 0; k < N*M; k++) w[k*B +: B] = wv;
        for (int j = 0; j < M; j++) begin
            b[j*B +: B]       = bv;
            exp_cur[j*B +: B] = ev;
        end
    endtask

    task automatic send(input logic hold);
        int n;
        n = 0;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", vec_t'(0), vec_t'(1));
                in_valid = 1'b0;
                return;
            end
        end
        tick();
        in_valid = hold;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            tick();
            n++;
            if (n > 200) begin
                check("drain_timeout", vec_t'(exp_q.size()), vec_t'(0));
                exp_q.delete();
                lat_q.delete();
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        tick();
        tick();
        check("rst_out_valid", vec_t'(out_valid), vec_t'(0));
        check("rst_busy", vec_t'(busy), vec_t'(0));
        check("rst_in_ready", vec_t'(in_ready), vec_t'(1));
        check("rst_out", out, '0);
        rst_n = 1'b1;
        tick();

        // Basic: 1*0.5 + 2*0.5 + 1.0 = 2.5
        set_uniform(32'h0001_0000, 32'h0002_0000, 32'h0000_8000,
                    32'h0001_0000, 32'h0002_8000);
        send(1'b0);
        check("busy_running", vec_t'(busy), vec_t'(1));
        drain();

        // Negative: -1*0.25 twice = -0.5
        set_uniform(32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_4000,
                    32'h0000_0000, 32'hFFFF_8000);
        send(1'b0);
        drain();

        // Overflow: 32767*2 does not fit Q16.16
`ifdef DECODER_MAC_SAT_EN
        set_uniform(32'h7FFF_0000, 32'h0000_0000, 32'h0002_0000,
                    32'h0000_0000, 32'h7FFF_FFFF);
`else
        set_uniform(32'h7FFF_0000, 32'h0000_0000, 32'h0002_0000,
                    32'h0000_0000, 32'hFFFE_0000);
`endif
        send(1'b0);
        drain();

        // Index pattern: w(j,0)=1, w(j,1)=j, b[j]=j -> out[j]=1+3j
        z = {32'h0002_0000, 32'h0001_0000};
        for (int j = 0; j < M; j++) begin
            w[(j*N+0)*B +: B] = 32'h0001_0000;
            w[(j*N+1)*B +: B] = B'(j) << 16;
            b[j*B +: B]       = B'(j) << 16;
            exp_cur[j*B +: B] = B'(1 + 3*j) << 16;
        end
        send(1'b0);
        drain();

        // Backpressure with in_valid held high
        set_uniform(32'h0001_0000, 32'h0002_0000, 32'h0000_8000,
                    32'h0001_0000, 32'h0002_8000);
        out_ready = 1'b0;
        send(1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 100) begin
                check("bp_valid_timeout", vec_t'(0), vec_t'(1));
                break;
            end
        end
        n0 = acc_log.size();
        for (int k = 0; k < 5; k++) begin
            check("bp_out_stable", out, exp_cur);
            check("bp_in_ready", vec_t'(in_ready), vec_t'(0));
            check("bp_no_accept", vec_t'(acc_log.size()), vec_t'(n0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (acc_log.size() == n0 && n < 50) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (acc_log.size() == n0)
            check("bp_second_accept", vec_t'(0), vec_t'(1));
        else
            check("bp_accept_cycle", vec_t'(acc_log[$]), vec_t'(hs_cyc + 1));
        drain();

        // Reset mid-operation
        send(1'b0);
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", vec_t'(out_valid), vec_t'(0));
        check("mid_rst_busy", vec_t'(busy), vec_t'(0));
        check("mid_rst_out", out, '0);
        check("mid_rst_in_ready", vec_t'(in_ready), vec_t'(1));
        exp_q.delete();
        lat_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(1'b0);
        drain();

        // Back-to-back: second z = {4.0, -2.0} -> 2 - 1 + 1 = 2.0
        n0 = acc_log.size();
        send(1'b0);
        z = {32'hFFFE_0000, 32'h0004_0000};
        for (int j = 0; j < M; j++) exp_cur[j*B +: B] = 32'h0002_0000;
        send(1'b0);
        if (acc_log.size() >= n0 + 2)
            check("b2b_spacing", vec_t'(acc_log[n0+1] - acc_log[n0]), vec_t'(29));
        else
            check("b2b_accepts", vec_t'(acc_log.size() - n0), vec_t'(2));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
